icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Control FSM driving the icache tag array: issues tag lookups for CPU fetches, reads hit/valid,
//  and on a miss runs an 8-beat burst read to memory, fills the data RAM and writes the new tag.
//  Also executes index-invalidate cache ops. Sits between the fetch stage, the tag/data RAMs and the AXI read port.
// PARAMETERS
//  LINE_WORDS   8    words per line (32 B line, offset addr[4:0]); fixes burst length
//  INDEX_W      7    index width, addr[11:5] (128 sets)
//  TAG_W        20   tag width, addr[31:12]; tag entry = {valid, tag} = 21 bits
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-low
//  cpu_req        in   1   fetch request
//  cpu_addr       in   32  fetch address (word aligned)
//  cpu_req_ready  out  1   request accepted this cycle
//  cpu_rvalid     out  1   fetch data valid (1-cycle pulse)
//  cpu_rdata      out  32  fetch data
//  op_req         in   1   index-invalidate request
//  op_addr        in   32  invalidate address (index addr[11:5])
//  op_ack         out  1   invalidate done (1-cycle pulse)
//  tag_addr       out  32  address to tag array (held stable while a lookup is pending)
//  tag_wen        out  1   tag write (refill)
//  tag_op         out  1   tag write (invalidate)
//  tag_wdata      out  21  {valid, tag}
//  tag_hit        in   1   tag match for address presented previous cycle
//  tag_valid      in   1   valid bit for address presented previous cycle
//  tag_work       in   1   tag array reset sweep complete
//  data_windex    out  10  data RAM word address {index, word}
//  data_wen       out  1   data RAM write
//  data_wdata     out  32  data RAM write data
//  data_rdata     in   32  data RAM read data (sync, 1-cycle, addressed by tag_addr[11:2])
//  mem_arvalid    out  1   AR valid
//  mem_araddr     out  32  line address {addr[31:5],5'b0}
//  mem_arlen      out  8   constant LINE_WORDS-1 = 7
//  mem_arready    in   1   AR ready
//  mem_rvalid     in   1   R valid
//  mem_rdata      in   32  R data
//  mem_rlast      in   1   R last
//  mem_rready     out  1   R ready
// BEHAVIOUR
//  Reset (rst=0): state INIT; all outputs 0; counters/latches 0. Reset mid-refill aborts immediately, AR dropped.
//  States: INIT -> IDLE when tag_work=1. Nothing accepted in INIT (cpu_req_ready=0, op_req ignored).
//  IDLE: cpu_req_ready=1 unless op_req=1 (op wins simultaneous events). On accept latch addr, tag_addr=cpu_addr
//   same cycle -> LOOKUP. On op_req: tag_op=1, tag_wdata=0, tag_addr=op_addr, op_ack=1 same cycle, stay IDLE.
//  LOOKUP (accept+1): tag_addr held. tag_hit&tag_valid -> cpu_rvalid=1, cpu_rdata=data_rdata -> IDLE.
//   Hit latency = 1 cycle after accept. Else -> AR.
//  AR: mem_arvalid=1, araddr=line addr, arlen=7, held until mem_arready -> R.
//  R: mem_rready=1; each rvalid beat: data_wen=1, data_windex={index,cnt}, cnt+=1 (3-bit, wraps);
//   beat with cnt==addr[4:2] captured as critical word. rvalid&rlast -> TAGW (cnt reset 0).
//   Beats after the 8th without rlast overwrite from word 0 (wrap); early rlast still ends refill.
//  TAGW: tag_wen=1, tag_wdata={1'b1,addr[31:12]}, tag_addr=latched addr; cpu_rvalid=1 with captured
//   word -> IDLE. Miss latency = accept + 2 + AR wait + beats.
//  tag_wen and tag_op never both 1. data_wen only in R. cpu_req_ready=0 outside IDLE.
// STRUCTURE
//  Shared icache_defs.vh: LINE_WORDS, INDEX_W, TAG_W, state encodings (INIT/IDLE/LOOKUP/AR/R/TAGW),
//  tag-entry field macros shared with the tag array. Single module; no sub-module needed.
// TESTING
//  Reset, tag_work=0 for 130 cycles, cpu_req=1 -> cpu_req_ready=0 until tag_work=1.
//  Miss 0x0000_1234 -> araddr 0x0000_1220, arlen 7, 8 beats D0..D7 written idx 0x11 words 0..7,
//   tag_wdata=0x1_00001, cpu_rdata=D5.
//  Re-fetch 0x0000_1238 -> hit, cpu_rvalid exactly 1 cycle after accept, rdata=D6, no arvalid.
//  op_req and cpu_req same cycle, op_addr 0x1220 -> tag_op=1, tag_wdata=0, op_ack; then fetch misses.
//  mem_arready delayed 5 cycles, rvalid gaps -> arvalid/araddr stable, only valid beats written.
//  rst=0 during beat 3 of refill -> all outputs 0 next cycle, state INIT, no tag_wen issued.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared icache refill definitions: geometry, FSM states and tag-entry layout.
// Imported by the refill controller, its bus interface and the tag array.
package icache_refill_ctrl_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 8;
    localparam int INDEX_W    = 7;
    localparam int TAG_W      = 20;
    localparam int WORD_W     = $clog2(LINE_WORDS);
    localparam int OFS_W      = WORD_W + 2;
    localparam int WINDEX_W   = INDEX_W + WORD_W;

    localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_AR,
        ST_R,
        ST_TAGW
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    function automatic tag_entry_t make_tag_entry(input logic [ADDR_W-1:0] addr);
        tag_entry_t e;
        e.valid = 1'b1;
        e.tag   = addr[ADDR_W-1 -: TAG_W];
        return e;
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle between the refill controller and fetch stage, tag/data RAMs and AXI read port.
// master = controller side, slave = environment side.
interface icache_refill_ctrl_if;
    import icache_refill_ctrl_pkg::*;

    logic                cpu_req;
    logic [ADDR_W-1:0]   cpu_addr;
    logic                cpu_req_ready;
    logic                cpu_rvalid;
    logic [DATA_W-1:0]   cpu_rdata;

    logic                op_req;
    logic [ADDR_W-1:0]   op_addr;
    logic                op_ack;

    logic [ADDR_W-1:0]   tag_addr;
    logic                tag_wen;
    logic                tag_op;
    logic [TAG_W:0]      tag_wdata;
    logic                tag_hit;
    logic                tag_valid;
    logic                tag_work;

    logic [WINDEX_W-1:0] data_windex;
    logic                data_wen;
    logic [DATA_W-1:0]   data_wdata;
    logic [DATA_W-1:0]   data_rdata;

    logic                mem_arvalid;
    logic [ADDR_W-1:0]   mem_araddr;
    logic [7:0]          mem_arlen;
    logic                mem_arready;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rlast;
    logic                mem_rready;

    modport master (
        input  cpu_req, cpu_addr, op_req, op_addr,
        input  tag_hit, tag_valid, tag_work, data_rdata,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        output cpu_req_ready, cpu_rvalid, cpu_rdata, op_ack,
        output tag_addr, tag_wen, tag_op, tag_wdata,
        output data_windex, data_wen, data_wdata,
        output mem_arvalid, mem_araddr, mem_arlen, mem_rready
    );

    modport slave (
        output cpu_req, cpu_addr, op_req, op_addr,
        output tag_hit, tag_valid, tag_work, data_rdata,
        output mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        input  cpu_req_ready, cpu_rvalid, cpu_rdata, op_ack,
        input  tag_addr, tag_wen, tag_op, tag_wdata,
        input  data_windex, data_wen, data_wdata,
        input  mem_arvalid, mem_araddr, mem_arlen, mem_rready
    );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache refill controller: tag lookup for fetches, 8-beat line refill on miss,
// critical-word return and index-invalidate ops.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    icache_refill_ctrl_if.master bus
);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:2]   r_addr;
    logic [WORD_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_crit;

    logic                w_accept;
    logic                w_beat;
    logic                w_hit;
    logic [ADDR_W-1:0]   w_addr_full;

    assign w_addr_full = {r_addr, 2'b00};
    assign w_accept    = (r_state == ST_IDLE) && bus.cpu_req && !bus.op_req;
    assign w_beat      = (r_state == ST_R) && bus.mem_rvalid;
    assign w_hit       = bus.tag_hit && bus.tag_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:   if (bus.tag_work) w_state_next = ST_IDLE;
            ST_IDLE:   if (w_accept) w_state_next = ST_LOOKUP;
            ST_LOOKUP: w_state_next = w_hit ? ST_IDLE : ST_AR;
            ST_AR:     if (bus.mem_arready) w_state_next = ST_R;
            ST_R:      if (bus.mem_rvalid && bus.mem_rlast) w_state_next = ST_TAGW;
            ST_TAGW:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_INIT;
        endcase
    end

    // Beat counter wraps at the line size, so an overlong burst rewrites the line from word 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_crit <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= bus.cpu_addr[ADDR_W-1:2];
            end
            if (w_beat) begin
                r_cnt <= bus.mem_rlast ? '0 : r_cnt + 1'b1;
                if (r_cnt == r_addr[OFS_W-1:2]) begin
                    r_crit <= bus.mem_rdata;
                end
            end
        end
    end

    always_comb begin
        bus.cpu_req_ready = 1'b0;
        bus.cpu_rvalid    = 1'b0;
        bus.cpu_rdata     = '0;
        bus.op_ack        = 1'b0;
        bus.tag_addr      = '0;
        bus.tag_wen       = 1'b0;
        bus.tag_op        = 1'b0;
        bus.tag_wdata     = '0;
        bus.data_windex   = '0;
        bus.data_wen      = 1'b0;
        bus.data_wdata    = '0;
        bus.mem_arvalid   = 1'b0;
        bus.mem_araddr    = '0;
        bus.mem_arlen     = '0;
        bus.mem_rready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // An invalidate takes the tag port this cycle, so the fetch must wait.
                if (bus.op_req) begin
                    bus.tag_op   = 1'b1;
                    bus.op_ack   = 1'b1;
                    bus.tag_addr = bus.op_addr;
                end else begin
                    bus.cpu_req_ready = 1'b1;
                    bus.tag_addr      = bus.cpu_addr;
                end
            end
            ST_LOOKUP: begin
                bus.tag_addr = w_addr_full;
                if (w_hit) begin
                    bus.cpu_rvalid = 1'b1;
                    bus.cpu_rdata  = bus.data_rdata;
                end
            end
            ST_AR: begin
                bus.tag_addr    = w_addr_full;
                bus.mem_arvalid = 1'b1;
                bus.mem_araddr  = line_addr(w_addr_full);
                bus.mem_arlen   = BURST_LEN;
            end
            ST_R: begin
                bus.tag_addr   = w_addr_full;
                bus.mem_rready = 1'b1;
                if (bus.mem_rvalid) begin
                    bus.data_wen    = 1'b1;
                    bus.data_windex = {r_addr[OFS_W+INDEX_W-1:OFS_W], r_cnt};
                    bus.data_wdata  = bus.mem_rdata;
                end
            end
            ST_TAGW: begin
                bus.tag_addr   = w_addr_full;
                bus.tag_wen    = 1'b1;
                bus.tag_wdata  = make_tag_entry(w_addr_full);
                bus.cpu_rvalid = 1'b1;
                bus.cpu_rdata  = r_crit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with behavioural tag array, data RAM and AXI read slave.
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    logic clk;
    logic rst;
    icache_refill_ctrl_if bus ();

    icache_refill_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int resp_cnt = 0;
    int ar_cycles = 0;

    logic [31:0] exp_rdata[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_tag[$];
    logic [41:0] exp_wr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Environment models: tag array and data RAM, both with 1-cycle registered read
    logic [20:0] tag_mem [0:127];
    logic [31:0] data_mem [0:1023];

    initial begin
        for (int i = 0; i < 128; i++) tag_mem[i] = '0;
        for (int i = 0; i < 1024; i++) data_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (bus.tag_wen) tag_mem[bus.tag_addr[11:5]] <= bus.tag_wdata;
        else if (bus.tag_op) tag_mem[bus.tag_addr[11:5]] <= '0;
        bus.tag_hit   <= (tag_mem[bus.tag_addr[11:5]][19:0] == bus.tag_addr[31:12]);
        bus.tag_valid <= tag_mem[bus.tag_addr[11:5]][20];
        if (bus.data_wen) data_mem[bus.data_windex] <= bus.data_wdata;
        bus.data_rdata <= data_mem[bus.tag_addr[11:2]];
    end

    // Monitor / scoreboard
    logic        prev_ar = 1'b0;
    logic [31:0] held_araddr = '0;
    logic [31:0] e32;
    logic [41:0] e42;

    always @(negedge clk) begin
        if (bus.cpu_rvalid) begin
            resp_cnt++;
            $display("[%0t] fetch resp rdata=%h", $time, bus.cpu_rdata);
            if (exp_rdata.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
            else begin
                e32 = exp_rdata.pop_front();
                check("cpu_rdata", bus.cpu_rdata, e32);
            end
        end
        if (bus.data_wen) begin
            $display("[%0t] data write idx=%h data=%h", $time, bus.data_windex, bus.data_wdata);
            if (exp_wr.size() == 0) check("data_wen_unexpected", 32'd1, 32'd0);
            else begin
                e42 = exp_wr.pop_front();
                check("data_windex", 32'(bus.data_windex), 32'(e42[41:32]));
                check("data_wdata", bus.data_wdata, e42[31:0]);
            end
        end
        if (bus.tag_wen || bus.tag_op)
            check("tag_wen_op_excl", 32'(bus.tag_wen & bus.tag_op), 32'd0);
        if (bus.tag_wen) begin
            $display("[%0t] tag write addr=%h wdata=%h", $time, bus.tag_addr, bus.tag_wdata);
            if (exp_tag.size() == 0) check("tag_wen_unexpected", 32'd1, 32'd0);
            else begin
                e32 = exp_tag.pop_front();
                check("tag_wdata", 32'(bus.tag_wdata), e32);
            end
        end
        if (bus.mem_rvalid) check("mem_rready", 32'(bus.mem_rready), 32'd1);
        if (bus.mem_arvalid) begin
            ar_cycles++;
            if (!prev_ar) begin
                $display("[%0t] AR araddr=%h arlen=%0d", $time, bus.mem_araddr, bus.mem_arlen);
                if (exp_ar.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
                else begin
                    e32 = exp_ar.pop_front();
                    check("araddr", bus.mem_araddr, e32);
                end
                check("arlen", 32'(bus.mem_arlen), 32'd7);
                held_araddr <= bus.mem_araddr;
            end else begin
                check("araddr_stable", bus.mem_araddr, held_araddr);
            end
        end
        prev_ar <= bus.mem_arvalid;
    end

    function automatic logic all_outs_zero();
        return ~|{bus.cpu_req_ready, bus.cpu_rvalid, bus.cpu_rdata, bus.op_ack,
                  bus.tag_addr, bus.tag_wen, bus.tag_op, bus.tag_wdata,
                  bus.data_windex, bus.data_wen, bus.data_wdata,
                  bus.mem_arvalid, bus.mem_araddr, bus.mem_arlen, bus.mem_rready};
    endfunction

    task automatic send_req(input logic [31:0] addr);
        int n;
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        n = 0;
        @(negedge clk);
        while (!bus.cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic grant_ar(input int delay);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mem_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arvalid_timeout", 32'(n < 20), 32'd1);
        repeat (delay) @(posedge clk);
        @(posedge clk); #1;
        bus.mem_arready = 1'b1;
        @(posedge clk); #1;
        bus.mem_arready = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] addr, input int i, input logic [31:0] data,
                             input bit last, input bit gap);
        if (gap) begin
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        bus.mem_rlast  = last;
        exp_wr.push_back({addr[11:5], 3'(i), data});
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rlast  = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    // hit: data is the expected word; miss: data is the base of the burst (beat i = data+i)
    task automatic fetch(input logic [31:0] addr, input bit hit, input logic [31:0] data,
                         input int ar_delay, input bit gaps);
        int ar0;
        int r0;
        int n;
        ar0 = ar_cycles;
        r0  = resp_cnt;
        if (hit) exp_rdata.push_back(data);
        else begin
            exp_rdata.push_back(data + 32'(addr[4:2]));
            exp_ar.push_back({addr[31:5], 5'b0});
            exp_tag.push_back({11'b0, 1'b1, addr[31:12]});
        end
        send_req(addr);
        if (hit) begin
            @(negedge clk);
            check("hit_latency", 32'(bus.cpu_rvalid), 32'd1);
            check("lookup_tag_addr", bus.tag_addr, addr);
        end else begin
            grant_ar(ar_delay);
            for (int i = 0; i < 8; i++)
                send_beat(addr, i, data + 32'(i), i == 7, gaps && (i % 2 == 1));
        end
        n = 0;
        while (resp_cnt == r0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resp_timeout", 32'(resp_cnt != r0), 32'd1);
        if (hit) check("hit_no_arvalid", 32'(ar_cycles - ar0), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst             = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.cpu_addr    = '0;
        bus.op_req      = 1'b0;
        bus.op_addr     = '0;
        bus.tag_work    = 1'b0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rlast   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", 32'(all_outs_zero()), 32'd1);

        // Tag sweep not done: nothing is accepted, invalidates ignored
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_1234;
        seen = 0;
        for (int i = 0; i < 130; i++) begin
            bus.op_req = (i >= 60 && i < 64);
            @(negedge clk);
            if (bus.cpu_req_ready || bus.op_ack || bus.tag_op) seen++;
        end
        check("init_nothing_accepted", 32'(seen), 32'd0);
        @(posedge clk); #1;
        bus.op_req   = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.tag_work = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_ready", 32'(bus.cpu_req_ready), 32'd1);

        fetch(32'h0000_1234, 1'b0, 32'hD000_0000, 0, 1'b0);
        fetch(32'h0000_1238, 1'b1, 32'hD000_0006, 0, 1'b0);

        // Invalidate collides with a fetch: the op wins
        @(posedge clk); #1;
        bus.op_req   = 1'b1;
        bus.op_addr  = 32'h0000_1220;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_1234;
        @(negedge clk);
        $display("[%0t] invalidate addr=%h", $time, bus.op_addr);
        check("op_tag_op", 32'(bus.tag_op), 32'd1);
        check("op_ack", 32'(bus.op_ack), 32'd1);
        check("op_tag_wdata", 32'(bus.tag_wdata), 32'd0);
        check("op_tag_addr", bus.tag_addr, 32'h0000_1220);
        check("op_blocks_ready", 32'(bus.cpu_req_ready), 32'd0);
        @(posedge clk); #1;
        bus.op_req  = 1'b0;
        bus.cpu_req = 1'b0;

        fetch(32'h0000_1234, 1'b0, 32'hE000_0000, 5, 1'b1);
        fetch(32'h0000_1220, 1'b1, 32'hE000_0000, 0, 1'b0);
        fetch(32'h0000_5A44, 1'b0, 32'hA500_0000, 2, 1'b1);
        fetch(32'h0000_5A5C, 1'b1, 32'hA500_0007, 0, 1'b0);

        // Reset during the third beat aborts the refill
        exp_ar.push_back(32'h0000_8000);
        send_req(32'h0000_8000);
        grant_ar(0);
        send_beat(32'h0000_8000, 0, 32'hF000_0000, 1'b0, 1'b0);
        send_beat(32'h0000_8000, 1, 32'hF000_0001, 1'b0, 1'b0);
        rst = 1'b0;
        send_beat(32'h0000_8000, 2, 32'hF000_0002, 1'b0, 1'b0);
        @(negedge clk);
        check("abort_outputs_zero", 32'(all_outs_zero()), 32'd1);
        exp_ar.delete();
        exp_wr.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fetch(32'h0000_8000, 1'b0, 32'hC000_0000, 1, 1'b0);
        check("queues_drained", 32'(exp_rdata.size() + exp_ar.size() + exp_tag.size() + exp_wr.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
